// File: rtl/mul_err_pkg.sv
//==============================================================================
// Module  : mul_err_pkg
// Brief   : Shared types, default widths and helpers for the multiplier
//           error monitor.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package mul_err_pkg;

    localparam int c_AW_DEF    = 12;
    localparam int c_BW_DEF    = 12;
    localparam int c_CNT_W_DEF = 24;
    localparam int c_PW_DEF    = c_AW_DEF + c_BW_DEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    // Magnitude of the difference, computed without wrap-around.
    function automatic logic [c_PW_DEF-1:0] abs_diff(input logic [c_PW_DEF-1:0] x,
                                                     input logic [c_PW_DEF-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul_err_pipe.sv
//==============================================================================
// Module  : mul_err_pipe
// Brief   : Two-stage datapath: exact product (S1), then absolute error
//           against the approximate product (S2). Valid bits travel with data.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module mul_err_pipe
    import mul_err_pkg::*;
#(
    parameter  int AW = c_AW_DEF,
    parameter  int BW = c_BW_DEF,
    localparam int PW = AW + BW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [AW-1:0] i_a,
    input  logic [BW-1:0] i_b,
    input  logic [PW-1:0] i_o,
    output logic          o_valid,
    output logic [PW-1:0] o_err,
    output logic [AW-1:0] o_a,
    output logic [BW-1:0] o_b,
    output logic          o_busy
);

    logic          r_s1_valid;
    logic [PW-1:0] r_s1_exact;
    logic [PW-1:0] r_s1_o;
    logic [AW-1:0] r_s1_a;
    logic [BW-1:0] r_s1_b;

    logic          r_s2_valid;
    logic [PW-1:0] r_s2_err;
    logic [AW-1:0] r_s2_a;
    logic [BW-1:0] r_s2_b;

    logic [PW-1:0] w_err;

    // The package helper is fixed at the default width; other widths use
    // an equivalent inline expression.
    generate
        if (PW == c_PW_DEF) begin : g_pkg_abs
            assign w_err = abs_diff(r_s1_exact, r_s1_o);
        end else begin : g_inline_abs
            assign w_err = (r_s1_exact >= r_s1_o) ? (r_s1_exact - r_s1_o)
                                                  : (r_s1_o - r_s1_exact);
        end
    endgenerate

    // S1: register the exact product alongside the operands under test.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_exact <= '0;
            r_s1_o     <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            r_s1_valid <= i_valid;
            r_s1_exact <= PW'(i_a) * PW'(i_b);
            r_s1_o     <= i_o;
            r_s1_a     <= i_a;
            r_s1_b     <= i_b;
        end
    end

    // S2: register the full-width error magnitude.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_err   <= '0;
            r_s2_a     <= '0;
            r_s2_b     <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_err   <= w_err;
            r_s2_a     <= r_s1_a;
            r_s2_b     <= r_s1_b;
        end
    end

    assign o_valid = r_s2_valid;
    assign o_err   = r_s2_err;
    assign o_a     = r_s2_a;
    assign o_b     = r_s2_b;
    assign o_busy  = r_s1_valid | r_s2_valid;

endmodule

`default_nettype wire

// File: rtl/mul12u_err_monitor.sv
//==============================================================================
// Module  : mul12u_err_monitor
// Brief   : Accumulates error statistics (sum of |error|, worst-case error
//           with operands, erroneous-sample count) of an approximate
//           multiplier over a run of N samples.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module mul12u_err_monitor
    import mul_err_pkg::*;
#(
    parameter  int AW    = c_AW_DEF,
    parameter  int BW    = c_BW_DEF,
    parameter  int CNT_W = c_CNT_W_DEF,
    localparam int PW    = AW + BW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    n_samples,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AW-1:0]       in_a,
    input  logic [BW-1:0]       in_b,
    input  logic [PW-1:0]       in_o,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [PW+CNT_W-1:0] res_sum_ae,
    output logic [PW-1:0]       res_wce,
    output logic [AW-1:0]       res_wce_a,
    output logic [BW-1:0]       res_wce_b,
    output logic [CNT_W-1:0]    res_err_cnt
);

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0]    r_n;
    logic [CNT_W-1:0]    r_accepted;

    logic [PW+CNT_W-1:0] r_sum_ae;
    logic [PW-1:0]       r_wce;
    logic [AW-1:0]       r_wce_a;
    logic [BW-1:0]       r_wce_b;
    logic [CNT_W-1:0]    r_err_cnt;

    logic                w_accept;
    logic                w_start_ok;
    logic                w_last;
    logic                w_s2_valid;
    logic [PW-1:0]       w_s2_err;
    logic [AW-1:0]       w_s2_a;
    logic [BW-1:0]       w_s2_b;
    logic                w_pipe_busy;

    assign w_accept   = in_valid & in_ready;
    assign w_start_ok = (r_state == ST_IDLE) & start;
    assign w_last     = (r_accepted + CNT_W'(1)) == r_n;

    mul_err_pipe #(
        .AW (AW),
        .BW (BW)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_accept),
        .i_a     (in_a),
        .i_b     (in_b),
        .i_o     (in_o),
        .o_valid (w_s2_valid),
        .o_err   (w_s2_err),
        .o_a     (w_s2_a),
        .o_b     (w_s2_b),
        .o_busy  (w_pipe_busy)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a zero-length run goes straight to reporting.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (n_samples != '0) ? ST_RUN : ST_REPORT;
                end
            end
            ST_RUN: begin
                if (w_accept && w_last) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!w_pipe_busy) begin
                    w_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (res_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs depend only on state and the acceptance counter.
    always_comb begin
        busy      = (r_state != ST_IDLE);
        in_ready  = (r_state == ST_RUN) && (r_accepted < r_n);
        res_valid = (r_state == ST_REPORT);
    end

    // Run length is latched at start so later changes on n_samples are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n        <= '0;
            r_accepted <= '0;
        end else if (w_start_ok) begin
            r_n        <= n_samples;
            r_accepted <= '0;
        end else if (w_accept) begin
            r_accepted <= r_accepted + CNT_W'(1);
        end
    end

    // S3: statistics; strict compare keeps the first sample on WCE ties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum_ae  <= '0;
            r_wce     <= '0;
            r_wce_a   <= '0;
            r_wce_b   <= '0;
            r_err_cnt <= '0;
        end else if (w_start_ok) begin
            r_sum_ae  <= '0;
            r_wce     <= '0;
            r_wce_a   <= '0;
            r_wce_b   <= '0;
            r_err_cnt <= '0;
        end else if (w_s2_valid) begin
            r_sum_ae <= r_sum_ae + {{CNT_W{1'b0}}, w_s2_err};
            if (w_s2_err > r_wce) begin
                r_wce   <= w_s2_err;
                r_wce_a <= w_s2_a;
                r_wce_b <= w_s2_b;
            end
            if (w_s2_err != '0) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign res_sum_ae  = r_sum_ae;
    assign res_wce     = r_wce;
    assign res_wce_a   = r_wce_a;
    assign res_wce_b   = r_wce_b;
    assign res_err_cnt = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mul12u_err_monitor.sv
//==============================================================================
// Module  : tb_mul12u_err_monitor
// Brief   : Directed and randomized self-checking bench for the multiplier
//           error monitor, with a behavioural statistics model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mul12u_err_monitor;

    localparam int AW    = 12;
    localparam int BW    = 12;
    localparam int CNT_W = 24;
    localparam int PW    = AW + BW;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [CNT_W-1:0]    n_samples;
    logic                busy;
    logic                in_valid;
    logic                in_ready;
    logic [AW-1:0]       in_a;
    logic [BW-1:0]       in_b;
    logic [PW-1:0]       in_o;
    logic                res_valid;
    logic                res_ready;
    logic [PW+CNT_W-1:0] res_sum_ae;
    logic [PW-1:0]       res_wce;
    logic [AW-1:0]       res_wce_a;
    logic [BW-1:0]       res_wce_b;
    logic [CNT_W-1:0]    res_err_cnt;

    int total = 0;
    int bad   = 0;

    // Reference statistics, computed from plain integer arithmetic.
    longint m_sum;
    longint m_wce;
    longint m_wa;
    longint m_wb;
    longint m_cnt;

    always #5 clk = ~clk;

    mul12u_err_monitor #(
        .AW    (AW),
        .BW    (BW),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .n_samples   (n_samples),
        .busy        (busy),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_o        (in_o),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum_ae  (res_sum_ae),
        .res_wce     (res_wce),
        .res_wce_a   (res_wce_a),
        .res_wce_b   (res_wce_b),
        .res_err_cnt (res_err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_sum = 0; m_wce = 0; m_wa = 0; m_wb = 0; m_cnt = 0;
    endtask

    task automatic model_add(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [PW-1:0] o);
        longint ex;
        longint ol;
        longint e;
        ex = longint'(a) * longint'(b);
        ol = longint'(o);
        e  = (ex > ol) ? ex - ol : ol - ex;
        m_sum += e;
        if (e > m_wce) begin
            m_wce = e; m_wa = longint'(a); m_wb = longint'(b);
        end
        if (e != 0) m_cnt++;
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        n_samples = n[CNT_W-1:0];
        model_clear();
        tick();
        start     = 1'b0;
    endtask

    // Offer one sample (optionally after random idle cycles) and wait for acceptance.
    task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [PW-1:0] o,
                        input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_a = a; in_b = b; in_o = o; in_valid = 1'b1;
        for (int k = 0; k < 50 && !in_ready; k++) tick();
        chk("send_ready", {63'd0, in_ready}, 64'd1);
        if (in_ready) model_add(a, b, o);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_report();
        for (int k = 0; k < 200 && !res_valid; k++) tick();
        chk("report_valid", {63'd0, res_valid}, 64'd1);
    endtask

    task automatic check_res(input string tag);
        chk({tag, "_sum"},  64'(res_sum_ae),  64'(m_sum));
        chk({tag, "_wce"},  64'(res_wce),     64'(m_wce));
        chk({tag, "_wa"},   64'(res_wce_a),   64'(m_wa));
        chk({tag, "_wb"},   64'(res_wce_b),   64'(m_wb));
        chk({tag, "_cnt"},  64'(res_err_cnt), 64'(m_cnt));
    endtask

    task automatic ack();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("ack_idle_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int unsigned r;
        int unsigned r2;
        int          ready_cnt;
        logic [AW-1:0] ta;
        logic [BW-1:0] tb;
        longint        ex;
        longint        ol;

        rst_n = 1'b0; start = 1'b0; n_samples = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_o = '0; res_ready = 1'b0;
        model_clear();
        repeat (3) tick();

        // Reset state
        chk("rst_busy",   {63'd0, busy},      64'd0);
        chk("rst_ready",  {63'd0, in_ready},  64'd0);
        chk("rst_rvalid", {63'd0, res_valid}, 64'd0);
        check_res("rst");
        rst_n = 1'b1;
        tick();

        // Exact products give zero statistics
        do_start(4);
        send(12'd0,    12'd0,    24'd0,        1'b0);
        send(12'd4095, 12'd4095, 24'd16769025, 1'b0);
        send(12'd1,    12'd4095, 24'd4095,     1'b0);
        send(12'd123,  12'd456,  24'd56088,    1'b0);
        wait_report();
        check_res("exact");
        chk("exact_sum_const", 64'(res_sum_ae), 64'd0);
        ack();

        // Maximum error on every sample
        do_start(3);
        repeat (3) send(12'd4095, 12'd4095, 24'd0, 1'b0);
        wait_report();
        check_res("fixed");
        chk("fixed_sum_const", 64'(res_sum_ae), 64'd50307075);
        chk("fixed_wce_const", 64'(res_wce),    64'd16769025);
        ack();

        // WCE ties: first sample reaching the maximum wins
        do_start(3);
        send(12'd1, 12'd9, 24'd4,  1'b0);
        send(12'd2, 12'd7, 24'd9,  1'b0);
        send(12'd3, 12'd1, 24'd0,  1'b0);
        wait_report();
        check_res("tie");
        chk("tie_wa_const",  64'(res_wce_a),   64'd1);
        chk("tie_wb_const",  64'(res_wce_b),   64'd9);
        chk("tie_sum_const", 64'(res_sum_ae),  64'd13);
        ack();

        // Approximate product above the exact one
        do_start(1);
        send(12'd1, 12'd1, 24'd3, 1'b0);
        wait_report();
        chk("over_wce_const", 64'(res_wce), 64'd2);
        check_res("over");
        ack();

        // Handshake: random valid gaps, back-pressure on the result
        do_start(2);
        for (int i = 0; i < 2; i++) begin
            r = $urandom;
            send(r[11:0], r[23:12], {r[31:24], r[15:0]}, 1'b1);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("hs_ready_low", {63'd0, in_ready}, 64'd0);
            tick();
        end
        in_valid = 1'b0;
        wait_report();
        for (int i = 0; i < 10; i++) begin
            start     = (i == 5);
            n_samples = 24'd7;
            chk("hs_hold_valid", {63'd0, res_valid}, 64'd1);
            chk("hs_hold_sum",   64'(res_sum_ae),    64'(m_sum));
            tick();
        end
        start = 1'b0;
        check_res("hs");
        ack();
        check_res("hs_after_ack");
        tick();
        chk("hs_start_ignored", {63'd0, busy}, 64'd0);

        // Zero-length run reports all zero
        do_start(0);
        tick();
        chk("n0_valid", {63'd0, res_valid}, 64'd1);
        check_res("n0");
        ack();

        // Reset in the middle of a run
        do_start(5);
        send(12'd4095, 12'd4095, 24'd0, 1'b0);
        send(12'd100,  12'd100,  24'd1, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy",   {63'd0, busy},      64'd0);
        chk("midrst_rvalid", {63'd0, res_valid}, 64'd0);
        do_start(1);
        send(12'd10, 12'd20, 24'd190, 1'b0);
        wait_report();
        check_res("midrst");
        ack();

        // Sustained throughput with random data
        do_start(1000);
        ready_cnt = 0;
        in_valid  = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            r  = $urandom;
            r2 = $urandom;
            ta = r[11:0];
            tb = r[23:12];
            ex = longint'(ta) * longint'(tb);
            case (r[31:30])
                2'd0:    ol = ex;
                2'd1:    ol = ex + longint'(r2[7:0]);
                2'd2:    ol = (ex > longint'(r2[9:0])) ? ex - longint'(r2[9:0]) : 0;
                default: ol = longint'(r2[23:0]);
            endcase
            if (ol > 64'd16777215) ol = 64'd16777215;
            in_a = ta; in_b = tb; in_o = ol[PW-1:0];
            if (in_ready) begin
                ready_cnt++;
                model_add(ta, tb, ol[PW-1:0]);
            end
            tick();
        end
        in_valid = 1'b0;
        chk("tp_ready_cycles", 64'(ready_cnt), 64'd1000);
        wait_report();
        check_res("tp");
        ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
